// File: rtl/lisnoc_router_nport_if.sv
// lisnoc_router_nport_if: per-port flit bus with per-(port,VC) valid/ready handshake
interface lisnoc_router_nport_if #(
  parameter int PORTS     = 5,
  parameter int VCHANNELS = 1,
  parameter int FLIT_W    = 34
);
  logic [PORTS*FLIT_W-1:0]    flit;
  logic [PORTS*VCHANNELS-1:0] valid;
  logic [PORTS*VCHANNELS-1:0] ready;
  modport master (output flit, valid, input ready);
  modport slave (input flit, valid, output ready);
endinterface

// File: rtl/lisnoc_router_nport.sv
// lisnoc_router_nport: N-port wormhole router, V virtual channels, per-(port,VC) input FIFOs,
// table routing and per-output round-robin arbitration into a single output register per port.
module lisnoc_router_nport #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 5,
  parameter int NUM_DESTS  = 32,
  parameter int PORTS      = 5,
  parameter int VCHANNELS  = 1,
  parameter int BUF_DEPTH  = 4,
  parameter logic [NUM_DESTS*PORTS-1:0] LOOKUP = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  lisnoc_router_nport_if.slave  in_if,
  lisnoc_router_nport_if.master out_if,
  output logic [PORTS-1:0]      drop_o
);
  localparam int FLIT_W = DATA_WIDTH + 2;
  localparam int N      = PORTS * VCHANNELS;
  localparam int AW     = $clog2(BUF_DEPTH);
  localparam int PW     = $clog2(PORTS);
  localparam int NW     = $clog2(N);

  logic [FLIT_W-1:0]              mem [N][BUF_DEPTH];
  logic [AW:0]                    wp [N];
  logic [AW:0]                    rp [N];
  logic                           run;
  logic [N-1:0]                   routed, lck;
  logic [PW-1:0]                  route [N];
  logic [PW-1:0]                  own [N];
  logic [NW-1:0]                  ptr [PORTS];
  logic [PORTS-1:0][FLIT_W-1:0]   oflit;
  logic [N-1:0]                   ovalid;
  logic [N-1:0]                   full, nempty, hdr, ok, req, drop, grant, push, pop;
  logic [FLIT_W-1:0]              head [N];
  logic [PORTS-1:0]               ent [N];
  logic [PW-1:0]                  tgt [N];
  logic [PW-1:0]                  dst [N];
  logic [PORTS-1:0]               gv, fire, free;
  logic [NW-1:0]                  win [PORTS];
  int                             gvc [PORTS];

  // run keeps in_ready low until the first edge after reset release
  assign in_if.ready  = {N{run}} & ~full;
  assign push         = in_if.valid & in_if.ready;
  assign pop          = drop | grant;
  assign out_if.flit  = oflit;
  assign out_if.valid = ovalid;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      full[i]   = (wp[i] ^ rp[i]) == {1'b1, {AW{1'b0}}};
      nempty[i] = wp[i] != rp[i];
      head[i]   = mem[i][rp[i][AW-1:0]];
      hdr[i]    = head[i][FLIT_W-2];
      ent[i]    = '0;
      for (int d = 0; d < NUM_DESTS; d++)
        if (int'(head[i][DATA_WIDTH-1 -: DEST_WIDTH]) == d) ent[i] = LOOKUP[d*PORTS +: PORTS];
      tgt[i] = '0;
      for (int o = PORTS - 1; o >= 0; o--)
        if (ent[i][o]) tgt[i] = PW'(o);
      ok[i]   = |ent[i];
      dst[i]  = routed[i] ? route[i] : tgt[i];
      req[i]  = nempty[i] & (routed[i]
                ? lck[int'(dst[i])*VCHANNELS + i%VCHANNELS] &&
                  int'(own[int'(dst[i])*VCHANNELS + i%VCHANNELS]) == i/VCHANNELS
                : hdr[i] & ok[i] & ~lck[int'(tgt[i])*VCHANNELS + i%VCHANNELS]);
      drop[i] = nempty[i] & ~routed[i] & ~(hdr[i] & ok[i]);
    end
  end

  // an output slot accepts a new flit only when empty or its held flit leaves this cycle
  always_comb begin
    grant = '0;
    for (int o = 0; o < PORTS; o++) begin
      fire[o] = |(ovalid[o*VCHANNELS +: VCHANNELS] & out_if.ready[o*VCHANNELS +: VCHANNELS]);
      free[o] = ~|ovalid[o*VCHANNELS +: VCHANNELS] | fire[o];
      gv[o]   = 1'b0;
      win[o]  = '0;
      for (int k = 0; k < N; k++)
        if (free[o] && !gv[o] && req[(int'(ptr[o]) + k) % N] &&
            int'(dst[(int'(ptr[o]) + k) % N]) == o) begin
          gv[o]  = 1'b1;
          win[o] = NW'((int'(ptr[o]) + k) % N);
        end
      gvc[o] = int'(win[o]) % VCHANNELS;
      if (gv[o]) grant[win[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk)
    for (int i = 0; i < N; i++)
      if (push[i]) mem[i][wp[i][AW-1:0]] <= in_if.flit[(i/VCHANNELS)*FLIT_W +: FLIT_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run    <= 1'b0;
      routed <= '0;
      lck    <= '0;
      ovalid <= '0;
      oflit  <= '0;
      drop_o <= '0;
      for (int i = 0; i < N; i++) begin
        wp[i]    <= '0;
        rp[i]    <= '0;
        route[i] <= '0;
        own[i]   <= '0;
      end
      for (int o = 0; o < PORTS; o++) ptr[o] <= '0;
    end else begin
      run <= 1'b1;
      for (int i = 0; i < N; i++) begin
        wp[i] <= wp[i] + {{AW{1'b0}}, push[i]};
        rp[i] <= rp[i] + {{AW{1'b0}}, pop[i]};
      end
      for (int p = 0; p < PORTS; p++) drop_o[p] <= |drop[p*VCHANNELS +: VCHANNELS];
      for (int o = 0; o < PORTS; o++) begin
        if (gv[o]) begin
          ovalid[o*VCHANNELS +: VCHANNELS] <= VCHANNELS'(1) << gvc[o];
          oflit[o] <= head[win[o]];
          ptr[o]   <= win[o] == NW'(N - 1) ? '0 : win[o] + 1'b1;
          // HEADER takes the (out,VC) lock, LAST releases it; SINGLE passes through unlocked
          if (head[win[o]][FLIT_W-1 -: 2] == 2'b01) begin
            lck[o*VCHANNELS + gvc[o]] <= 1'b1;
            own[o*VCHANNELS + gvc[o]] <= PW'(int'(win[o]) / VCHANNELS);
            routed[win[o]]            <= 1'b1;
            route[win[o]]             <= PW'(o);
          end else if (head[win[o]][FLIT_W-1 -: 2] == 2'b10) begin
            lck[o*VCHANNELS + gvc[o]] <= 1'b0;
            routed[win[o]]            <= 1'b0;
          end
        end else if (fire[o]) begin
          ovalid[o*VCHANNELS +: VCHANNELS] <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_lisnoc_router_nport.sv
// tb_lisnoc_router_nport: directed checks of routing, locking, arbitration, backpressure,
// drops and asynchronous reset on a 5-port, 2-VC router with dest d -> port d%5.
module tb_lisnoc_router_nport;
  localparam int P = 5, V = 2, FW = 34;

  function automatic logic [32*P-1:0] mk_lookup();
    logic [32*P-1:0] r = '0;
    for (int d = 0; d < 32; d++) r[d*P + d%P] = 1'b1;
    return r;
  endfunction
  localparam logic [32*P-1:0] LK = mk_lookup();

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [P-1:0] drop;
  int n_chk = 0, n_fail = 0;
  logic [63:0] got[$];
  logic [63:0] exp_q[$];

  lisnoc_router_nport_if #(.PORTS(P), .VCHANNELS(V), .FLIT_W(FW)) in_if ();
  lisnoc_router_nport_if #(.PORTS(P), .VCHANNELS(V), .FLIT_W(FW)) out_if ();

  lisnoc_router_nport #(
    .DATA_WIDTH(32), .DEST_WIDTH(6), .NUM_DESTS(32), .PORTS(P), .VCHANNELS(V),
    .BUF_DEPTH(4), .LOOKUP(LK)
  ) dut (
    .clk(clk), .rst(rst), .in_if(in_if), .out_if(out_if), .drop_o(drop)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [FW-1:0] fl(logic [1:0] t, int dest, int tag);
    return {t, 6'(dest), 26'(tag)};
  endfunction

  function automatic logic [FW-1:0] oflit(int o);
    return out_if.flit[o*FW +: FW];
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int p, int v, logic [FW-1:0] f);
    in_if.flit[p*FW +: FW] = f;
    in_if.valid[p*V+v]     = 1'b1;
  endtask

  initial begin
    int drops, other, saw;
    in_if.valid  = '0;
    in_if.flit   = '0;
    out_if.ready = '1;
    #12;
    check("rst_in_ready", in_if.ready, 0);
    check("rst_out_valid", out_if.valid, 0);
    check("rst_out_flit", out_if.flit, 0);
    check("rst_drop", drop, 0);
    rst = 1'b1;
    check("rel_in_ready_pre_edge", in_if.ready, 0);
    step();
    check("rel_in_ready", in_if.ready, 10'h3FF);

    // single flit p0 v1 to dest 3
    drive(0, 1, fl(2'b11, 3, 'h11));
    step();
    in_if.valid = '0;
    check("t1_valid_edge1", out_if.valid, 0);
    step();
    check("t1_valid_edge2", out_if.valid, 10'h080);
    check("t1_flit", oflit(3), fl(2'b11, 3, 'h11));
    step();
    check("t1_valid_cleared", out_if.valid, 0);

    // two packets contending for port 2 VC 0
    got.delete();
    exp_q = '{fl(2'b01, 2, 'h20), fl(2'b00, 2, 'h21), fl(2'b10, 2, 'h22),
              fl(2'b01, 2, 'h40), fl(2'b00, 2, 'h41), fl(2'b10, 2, 'h42)};
    for (int c = 0; c < 12; c++) begin
      in_if.valid = '0;
      if (c < 3) begin
        drive(0, 0, exp_q[c][FW-1:0]);
        drive(4, 0, exp_q[c+3][FW-1:0]);
      end
      step();
      if (out_if.valid[4]) got.push_back(64'(oflit(2)));
    end
    in_if.valid = '0;
    check("t2_count", got.size(), 6);
    for (int k = 0; k < 6; k++) check($sformatf("t2_flit%0d", k), got[k], exp_q[k]);

    // packets on VC0 (p0) and VC1 (p3) to port 1 interleave
    got.delete();
    exp_q = '{{2'b01, fl(2'b01, 1, 'h30)}, {2'b10, fl(2'b01, 1, 'h60)},
              {2'b01, fl(2'b00, 1, 'h31)}, {2'b10, fl(2'b00, 1, 'h61)},
              {2'b01, fl(2'b10, 1, 'h32)}, {2'b10, fl(2'b10, 1, 'h62)}};
    for (int c = 0; c < 12; c++) begin
      in_if.valid = '0;
      if (c < 3) begin
        drive(0, 0, exp_q[2*c][FW-1:0]);
        drive(3, 1, exp_q[2*c+1][FW-1:0]);
      end
      step();
      if (|out_if.valid[3:2]) got.push_back(64'({out_if.valid[3:2], oflit(1)}));
    end
    in_if.valid = '0;
    check("t3_count", got.size(), 6);
    for (int k = 0; k < 6; k++) check($sformatf("t3_flit%0d", k), got[k], exp_q[k]);

    // backpressure on port 4: out register plus four FIFO slots
    out_if.ready[9:8] = 2'b00;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_ready_before_push%0d", k), in_if.ready[4], 1);
      drive(2, 0, fl(2'b11, 4, 'h50 + k));
      step();
    end
    in_if.valid = '0;
    check("t4_ready_full", in_if.ready[4], 0);
    check("t4_held_valid", out_if.valid, 10'h100);
    check("t4_held_flit", oflit(4), fl(2'b11, 4, 'h50));
    step();
    step();
    check("t4_still_valid", out_if.valid, 10'h100);
    check("t4_still_flit", oflit(4), fl(2'b11, 4, 'h50));
    out_if.ready = '1;
    got.delete();
    for (int c = 0; c < 8; c++) begin
      if (out_if.valid[8]) got.push_back(64'(oflit(4)));
      step();
    end
    check("t4_count", got.size(), 5);
    for (int k = 0; k < 5; k++) check($sformatf("t4_flit%0d", k), got[k], 64'(fl(2'b11, 4, 'h50 + k)));

    // stray PAYLOAD and unroutable HEADER are both dropped
    drops = 0; other = 0; saw = 0;
    for (int c = 0; c < 8; c++) begin
      in_if.valid = '0;
      if (c == 0) drive(1, 0, fl(2'b00, 3, 'h70));
      if (c == 1) drive(1, 0, fl(2'b01, 40, 'h71));
      step();
      if (drop[1]) drops++;
      if (drop[0] | (|drop[4:2])) other++;
      if (|out_if.valid) saw++;
    end
    in_if.valid = '0;
    check("t5_drops", drops, 2);
    check("t5_other_drops", other, 0);
    check("t5_no_out_valid", saw, 0);
    check("t5_ready_after", in_if.ready[2], 1);

    // asynchronous reset mid-packet, then a fresh flit through the same output VC
    drive(0, 0, fl(2'b01, 2, 'h80));
    step();
    drive(0, 0, fl(2'b00, 2, 'h81));
    step();
    in_if.valid = '0;
    check("t6_pre_valid", out_if.valid, 10'h010);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_valid", out_if.valid, 0);
    check("t6_rst_ready", in_if.ready, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    check("t6_rel_ready", in_if.ready, 10'h3FF);
    drive(4, 0, fl(2'b11, 2, 'h90));
    step();
    in_if.valid = '0;
    step();
    check("t6_new_valid", out_if.valid, 10'h010);
    check("t6_new_flit", oflit(2), fl(2'b11, 2, 'h90));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
